mips_cpu_hilo_div_ctrl: RTL and testbench

//  Sequences the 32-cycle unsigned divider for MIPS DIV/DIVU and owns the HI/LO registers.
//  - Converts signed operands to magnitudes and applies the result signs.
//  - Handles MTHI/MTLO writes.
//  - Stalls MFHI/MFLO while a divide is in flight.
//  - Sits between decode/execute and the divider instance.

---
 rtl/mips_cpu_hilo_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mips_cpu_hilo_div_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_div_ctrl.sv
// HI/LO owner and sequencer for an external 32-cycle unsigned divider.
// Handles DIV/DIVU sign fix-up, MTHI/MTLO writes, MFHI/MFLO stall,
// abort and a WAIT timeout.
// Optional build macro: HILO_DBZ_PRESERVE_EN. When it is defined, a divide
// by zero leaves hi/lo untouched. When it is not defined, a divide by zero
// writes lo=all-ones and hi=the raw dividend.
module mips_cpu_hilo_div_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        op_ready,
  input  logic        abort,
  input  logic        mf_req,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz,
  output logic        timeout_err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIX} state_t;

  state_t        state_q, state_d;
  logic          qneg_q, qneg_d, rneg_q, rneg_d, zdiv_q, zdiv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic          start_q, start_d, dbz_q, dbz_d, tmo_q, tmo_d;
`ifndef HILO_DBZ_PRESERVE_EN
  logic [31:0]   raw_q, raw_d;
`endif

  logic is_div, accept;
  assign is_div = (op_code == 2'd1);
  assign accept = op_valid && (state_q == S_IDLE);

  assign op_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign stall        = mf_req && busy;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign dbz          = dbz_q;
  assign timeout_err  = tmo_q;
  assign div_start    = start_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

  // Next-state, operand latching and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zdiv_d  = zdiv_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    start_d = 1'b0;
    dbz_d   = 1'b0;
    tmo_d   = 1'b0;
`ifndef HILO_DBZ_PRESERVE_EN
    raw_d   = raw_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        case (op_code)
          2'd2: hi_d = rs_data;
          2'd3: lo_d = rs_data;
          default: begin
            qneg_d = is_div & (rs_data[31] ^ rt_data[31]);
            rneg_d = is_div & rs_data[31];
            dvd_d  = (is_div & rs_data[31]) ? -rs_data : rs_data;
            dvs_d  = (is_div & rt_data[31]) ? -rt_data : rt_data;
            // The divider's own zero-divisor result is not trusted, so skip it.
            zdiv_d = (rt_data == 32'd0);
`ifndef HILO_DBZ_PRESERVE_EN
            raw_d  = rs_data;
`endif
            if (rt_data == 32'd0) state_d = S_FIX;
            else begin
              state_d = S_START;
              start_d = 1'b1;
            end
          end
        endcase
      end
      S_START: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) state_d = S_IDLE;
        else if (div_done) state_d = S_FIX;
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (zdiv_q) begin
          dbz_d = 1'b1;
`ifndef HILO_DBZ_PRESERVE_EN
          lo_d  = 32'hFFFF_FFFF;
          hi_d  = raw_q;
`endif
        end else begin
          lo_d = qneg_q ? -div_quotient  : div_quotient;
          hi_d = rneg_q ? -div_remainder : div_remainder;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      start_q <= 1'b0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifndef HILO_DBZ_PRESERVE_EN
      raw_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zdiv_q  <= zdiv_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      start_q <= start_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
`ifndef HILO_DBZ_PRESERVE_EN
      raw_q   <= raw_d;
`endif
    end
  end
endmodule

// File: tb/tb_mips_cpu_hilo_div_ctrl.sv
// Bench for mips_cpu_hilo_div_ctrl: behavioural 32-cycle divider plus a
// signed-arithmetic reference for HI/LO and latency.
module tb_mips_cpu_hilo_div_ctrl;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0, reset = 1'b1;
  logic        op_valid = 1'b0, abort = 1'b0, mf_req = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        op_ready, stall, busy, dbz, timeout_err, div_start;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_done;

  int checks = 0, failures = 0;
  logic [31:0] mhi = '0, mlo = '0;
  bit hold_low = 1'b0;

  mips_cpu_hilo_div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready), .abort(abort),
    .mf_req(mf_req), .stall(stall), .busy(busy), .hi(hi), .lo(lo), .dbz(dbz),
    .timeout_err(timeout_err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Divider: done level rises 32 cycles after start (next cycle for a zero dividend).
  int dcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_done <= 1'b0; dcnt <= 100;
      div_quotient <= '0; div_remainder <= '0;
    end else if (div_start) begin
      div_quotient  <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
      div_remainder <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
      div_done      <= (div_dividend == 0) && !hold_low;
      dcnt          <= 0;
    end else if (dcnt < 100) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == 32 && !hold_low) div_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference result of one op on the architectural HI/LO.
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, b,
                        output logic [31:0] ehi, elo, output int lat);
    longint sa, sb, q, r;
    ehi = mhi; elo = mlo; lat = 0;
    if (op == 2'd2) ehi = a;
    else if (op == 2'd3) elo = a;
    else if (b == 0) begin
      lat = 1;
`ifndef HILO_DBZ_PRESERVE_EN
      elo = 32'hFFFF_FFFF; ehi = a;
`endif
    end else begin
      lat = (a == 0) ? 3 : 35;
      if (op == 2'd1) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        elo = 32'(q); ehi = 32'(r);
      end else begin
        elo = a / b; ehi = a % b;
      end
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, b);
    logic [31:0] ehi, elo, emag;
    int lat;
    ref_op(op, a, b, ehi, elo, lat);
    @(negedge clk);
    op_valid = 1'b1; op_code = op; rs_data = a; rt_data = b; mf_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      if (k == 0 && lat > 1) begin
        emag = (op == 2'd1 && a[31]) ? 32'd0 - a : a;
        chk("start_pulse", {31'd0, div_start}, 32'd1);
        chk("div_dividend", div_dividend, emag);
      end
      if (k == 1) chk("start_once", {31'd0, div_start}, 32'd0);
      if (k < lat) chk("stall_busy", {31'd0, stall}, 32'd1);
      if (k == lat - 1 && lat > 0) chk("lo_before", lo, mlo);
      if (k == lat) begin
        chk("lo", lo, elo);
        chk("hi", hi, ehi);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("stall_after", {31'd0, stall}, 32'd0);
        if (op < 2) chk("dbz", {31'd0, dbz}, {31'd0, b == 0});
      end
    end
    mf_req = 1'b0;
    mhi = ehi; mlo = elo;
  endtask

  task automatic accept_div(input logic [31:0] a, b);
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'd0; rs_data = a; rt_data = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, ehi, elo;
    logic [1:0] op;
    int lat, k;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", {31'd0, busy}, 0); chk("rst_ready", {31'd0, op_ready}, 1);
    chk("rst_pulses", {29'd0, div_start, dbz, timeout_err}, 0);
    chk("rst_dvd", div_dividend, 0); chk("rst_dvs", div_divisor, 0);
    reset = 1'b0;

    do_op(2'd0, 100, 7);
    do_op(2'd1, -32'sd7, 2);
    do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'd2, 32'hAAAA_0001, 0);
    do_op(2'd1, 5, 0);
    do_op(2'd0, 0, 9);
    do_op(2'd3, 32'h5555_0002, 0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: a = 0;
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      do_op(op, a, b);
    end

    // MTHI held while a divide is in flight is accepted only once IDLE.
    ref_op(2'd0, 1000, 3, ehi, elo, lat);
    accept_div(1000, 3);
    op_valid = 1'b1; op_code = 2'd2; rs_data = 32'h1234;
    for (k = 1; k <= 35; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 34) chk("mthi_blocked", hi, mhi);
    end
    chk("mthi_div_hi", hi, ehi);
    chk("mthi_div_lo", lo, elo);
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    chk("mthi_late", hi, 32'h1234);
    mhi = 32'h1234; mlo = elo;

    // Abort mid-WAIT: back to IDLE, no write, late done ignored.
    accept_div(50, 3);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      if (dbz || timeout_err || busy) seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, seen}, 0);
    chk("abort_hi", hi, mhi); chk("abort_lo", lo, mlo);
    do_op(2'd0, 9, 4);

    // Divider never finishes: timeout pulse after TIMEOUT WAIT cycles.
    hold_low = 1'b1;
    accept_div(77, 5);
    k = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (timeout_err) seen = 1'b1;
    end
    chk("tmo_seen", {31'd0, seen}, 1);
    chk("tmo_cycle", 32'(k), 32'(TIMEOUT + 1));
    chk("tmo_hi", hi, mhi); chk("tmo_lo", lo, mlo);
    chk("tmo_idle", {31'd0, busy}, 0);
    hold_low = 1'b0;

    // Async reset mid-divide.
    do_op(2'd3, 32'hDEAD_BEEF, 0);
    accept_div(1234, 5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_lo", lo, 0); chk("mid_rst_hi", hi, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    mhi = 0; mlo = 0;
    do_op(2'd1, -32'sd100, -32'sd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
